// File: rtl/tracer_chain_driver_pkg.sv
// Shared types for the tracer chain driver: FSM encoding and address/coordinate widths.
package tracer_chain_driver_pkg;

   localparam int unsigned CTR_AW = 10;
   localparam int unsigned PIX_AW = 17;
   localparam int unsigned ROW_W  = 8;
   localparam int unsigned COL_W  = 9;
   localparam int unsigned DATA_W = 8;

   typedef logic [CTR_AW-1:0] ctr_addr_t;
   typedef logic [PIX_AW-1:0] pix_addr_t;
   typedef logic [ROW_W-1:0]  row_t;
   typedef logic [COL_W-1:0]  col_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CTR_FETCH,
      ST_CTR_SHIFT,
      ST_CENTER,
      ST_STREAM,
      ST_DRAIN,
      ST_STORE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/tracer_chain_driver_raster_counter.sv
// Raster scan generator: row/col plus incrementally maintained linear address.
module tracer_raster_counter
   import tracer_chain_driver_pkg::*;
#(
   parameter int unsigned NUM_ROWS = 240,
   parameter int unsigned NUM_COLS = 320
)(
   input  logic      clk,
   input  logic      rst,
   input  logic      clear,
   input  logic      step,
   output row_t      row,
   output col_t      col,
   output pix_addr_t addr,
   output logic      last
);

   localparam row_t ROW_LAST = row_t'(NUM_ROWS - 1);
   localparam col_t COL_LAST = col_t'(NUM_COLS - 1);

   assign last = (row == ROW_LAST) && (col == COL_LAST);

   // Stepping past the final pixel wraps to zero so addr stays inside the frame.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         row  <= '0;
         col  <= '0;
         addr <= '0;
      end else if (step) begin
         if (last) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
         end else begin
            addr <= addr + 1'b1;
            if (col == COL_LAST) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tracer_chain_driver.sv
// Sequences one trace pass: serial contour load, center latch, pixel stream, drain, store.
module tracer_chain_driver
   import tracer_chain_driver_pkg::*;
#(
   parameter int unsigned NUM_ROWS      = 240,
   parameter int unsigned NUM_COLS      = 320,
   parameter int unsigned CONTOUR_WORDS = 128,
   parameter int unsigned DRAIN_CYCLES  = 16
)(
   input  logic              s_axi_aclk,
   input  logic              s_axi_areset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              ctr_rden,
   output logic [CTR_AW-1:0] ctr_addr,
   input  logic [DATA_W-1:0] ctr_rddata,
   output logic              pix_rden,
   output logic [PIX_AW-1:0] pix_addr,
   input  logic [DATA_W-1:0] pix_rddata,
   output logic              load_contour,
   output logic              contour_data,
   output logic              load_center,
   output logic              contour_rden,
   output logic              enh_ds_ena,
   output logic [ROW_W-1:0]  enh_ds_row,
   output logic [COL_W-1:0]  enh_ds_col,
   output logic [DATA_W-1:0] enh_ds_data,
   output logic              store_trace
);

   localparam ctr_addr_t   CTR_LAST   = ctr_addr_t'(CONTOUR_WORDS - 1);
   localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

   state_t      state;
   logic [2:0]  bit_cnt;
   logic [6:0]  shift_q;
   logic [15:0] drain_cnt;
   data_t       data_q;
   row_t        rc_row;
   col_t        rc_col;
   pix_addr_t   rc_addr;
   logic        rc_last;

   tracer_raster_counter #(
      .NUM_ROWS (NUM_ROWS),
      .NUM_COLS (NUM_COLS)
   ) u_raster (
      .clk   (s_axi_aclk),
      .rst   (s_axi_areset),
      .clear (state == ST_IDLE),
      .step  (state == ST_STREAM),
      .row   (rc_row),
      .col   (rc_col),
      .addr  (rc_addr),
      .last  (rc_last)
   );

   assign pix_addr = rc_addr;

   // Bit 0 comes straight from the memory in the first shift cycle; the rest from the captured word.
   assign contour_data = load_contour & ((bit_cnt == 3'd0) ? ctr_rddata[0] : shift_q[0]);

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         state        <= ST_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         ctr_rden     <= 1'b0;
         ctr_addr     <= '0;
         pix_rden     <= 1'b0;
         load_contour <= 1'b0;
         load_center  <= 1'b0;
         store_trace  <= 1'b0;
         bit_cnt      <= '0;
         shift_q      <= '0;
         drain_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_CTR_FETCH;
                  busy     <= 1'b1;
                  ctr_rden <= 1'b1;
                  ctr_addr <= '0;
               end
            end
            ST_CTR_FETCH: begin
               ctr_rden     <= 1'b0;
               load_contour <= 1'b1;
               bit_cnt      <= '0;
               state        <= ST_CTR_SHIFT;
            end
            ST_CTR_SHIFT: begin
               bit_cnt <= bit_cnt + 1'b1;
               shift_q <= (bit_cnt == 3'd0) ? ctr_rddata[7:1] : {1'b0, shift_q[6:1]};
               if (bit_cnt == 3'd7) begin
                  load_contour <= 1'b0;
                  if (ctr_addr == CTR_LAST) begin
                     load_center <= 1'b1;
                     state       <= ST_CENTER;
                  end else begin
                     ctr_addr <= ctr_addr + 1'b1;
                     ctr_rden <= 1'b1;
                     state    <= ST_CTR_FETCH;
                  end
               end
            end
            ST_CENTER: begin
               load_center <= 1'b0;
               pix_rden    <= 1'b1;
               state       <= ST_STREAM;
            end
            ST_STREAM: begin
               if (rc_last) begin
                  pix_rden  <= 1'b0;
                  drain_cnt <= '0;
                  state     <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               drain_cnt <= drain_cnt + 1'b1;
               if (drain_cnt == DRAIN_LAST) begin
                  store_trace <= 1'b1;
                  state       <= ST_STORE;
               end
            end
            ST_STORE: begin
               store_trace <= 1'b0;
               done        <= 1'b1;
               state       <= ST_DONE;
            end
            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Chain-side pixel strobes trail the read by the memory latency; data passes through, then holds.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         enh_ds_ena   <= 1'b0;
         contour_rden <= 1'b0;
         enh_ds_row   <= '0;
         enh_ds_col   <= '0;
         data_q       <= '0;
      end else begin
         enh_ds_ena   <= pix_rden;
         contour_rden <= pix_rden;
         if (pix_rden) begin
            enh_ds_row <= rc_row;
            enh_ds_col <= rc_col;
         end
         if (enh_ds_ena) data_q <= pix_rddata;
      end
   end

   assign enh_ds_data = enh_ds_ena ? pix_rddata : data_q;

endmodule

// File: tb/tb_tracer_chain_driver.sv
// Scoreboard bench: small-parameter instance for function/abort tests, default instance for pass timing.
module tb_tracer_chain_driver;

   typedef struct {
      int       row;
      int       col;
      int       data;
      int       cyc;
   } px_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=event expected=none", name);
   endtask

   // ---------------- instance A: CONTOUR_WORDS=2, 2x3 frame, DRAIN=4
   logic        rst_a, start_a;
   logic        busy_a, done_a, ctr_rden_a, pix_rden_a, load_contour_a, contour_data_a;
   logic        load_center_a, contour_rden_a, enh_ds_ena_a, store_trace_a;
   logic [9:0]  ctr_addr_a;
   logic [16:0] pix_addr_a;
   logic [7:0]  ctr_rddata_a, pix_rddata_a, enh_ds_row_a, enh_ds_data_a;
   logic [8:0]  enh_ds_col_a;
   logic [61:0] outs_a;

   tracer_chain_driver #(
      .NUM_ROWS      (2),
      .NUM_COLS      (3),
      .CONTOUR_WORDS (2),
      .DRAIN_CYCLES  (4)
   ) dut_a (
      .s_axi_aclk   (clk),
      .s_axi_areset (rst_a),
      .start        (start_a),
      .busy         (busy_a),
      .done         (done_a),
      .ctr_rden     (ctr_rden_a),
      .ctr_addr     (ctr_addr_a),
      .ctr_rddata   (ctr_rddata_a),
      .pix_rden     (pix_rden_a),
      .pix_addr     (pix_addr_a),
      .pix_rddata   (pix_rddata_a),
      .load_contour (load_contour_a),
      .contour_data (contour_data_a),
      .load_center  (load_center_a),
      .contour_rden (contour_rden_a),
      .enh_ds_ena   (enh_ds_ena_a),
      .enh_ds_row   (enh_ds_row_a),
      .enh_ds_col   (enh_ds_col_a),
      .enh_ds_data  (enh_ds_data_a),
      .store_trace  (store_trace_a)
   );

   assign outs_a = {busy_a, done_a, ctr_rden_a, ctr_addr_a, pix_rden_a, pix_addr_a,
                    load_contour_a, contour_data_a, load_center_a, contour_rden_a,
                    enh_ds_ena_a, enh_ds_row_a, enh_ds_col_a, enh_ds_data_a, store_trace_a};

   logic [7:0] ctr_mem_a [0:1];
   logic [7:0] pix_mem_a [0:5];
   initial begin
      ctr_mem_a = '{8'hA5, 8'h3C};
      pix_mem_a = '{8'h11, 8'h2E, 8'h53, 8'h6C, 8'h9A, 8'hF0};
   end

   always @(posedge clk) begin
      if (ctr_rden_a) ctr_rddata_a <= ctr_mem_a[ctr_addr_a[0]];
      if (pix_rden_a) pix_rddata_a <= (pix_addr_a < 17'd6) ? pix_mem_a[pix_addr_a[2:0]] : 8'h00;
   end

   // ---------------- instance B: default parameters
   logic        rst_b, start_b;
   logic        busy_b, done_b, ctr_rden_b, pix_rden_b, load_contour_b, contour_data_b;
   logic        load_center_b, contour_rden_b, enh_ds_ena_b, store_trace_b;
   logic [9:0]  ctr_addr_b;
   logic [16:0] pix_addr_b;
   logic [7:0]  ctr_rddata_b, pix_rddata_b, enh_ds_row_b, enh_ds_data_b;
   logic [8:0]  enh_ds_col_b;
   logic [61:0] outs_b;

   tracer_chain_driver dut_b (
      .s_axi_aclk   (clk),
      .s_axi_areset (rst_b),
      .start        (start_b),
      .busy         (busy_b),
      .done         (done_b),
      .ctr_rden     (ctr_rden_b),
      .ctr_addr     (ctr_addr_b),
      .ctr_rddata   (ctr_rddata_b),
      .pix_rden     (pix_rden_b),
      .pix_addr     (pix_addr_b),
      .pix_rddata   (pix_rddata_b),
      .load_contour (load_contour_b),
      .contour_data (contour_data_b),
      .load_center  (load_center_b),
      .contour_rden (contour_rden_b),
      .enh_ds_ena   (enh_ds_ena_b),
      .enh_ds_row   (enh_ds_row_b),
      .enh_ds_col   (enh_ds_col_b),
      .enh_ds_data  (enh_ds_data_b),
      .store_trace  (store_trace_b)
   );

   assign outs_b = {busy_b, done_b, ctr_rden_b, ctr_addr_b, pix_rden_b, pix_addr_b,
                    load_contour_b, contour_data_b, load_center_b, contour_rden_b,
                    enh_ds_ena_b, enh_ds_row_b, enh_ds_col_b, enh_ds_data_b, store_trace_b};

   always @(posedge clk) begin
      if (ctr_rden_b) ctr_rddata_b <= ctr_addr_b[7:0];
      if (pix_rden_b) pix_rddata_b <= pix_addr_b[7:0];
   end

   // ---------------- scoreboard queues
   int  bit_q_a[$];
   int  ctr_q_a[$];
   px_t px_q_a[$];
   int  st_q_a[$];
   int  dn_q_a[$];
   int  st_q_b[$];
   int  dn_q_b[$];
   int  lc_cnt_a  = 0;
   int  ena_cnt_b = 0;
   int  max_addr_b = 0;

   // Expected contour bits for words 0xA5, 0x3C, LSB first.
   int exp_bits [16] = '{1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0};

   task automatic push_pass_a(input int s, input int n_px, input bit full);
      px_t p;
      foreach (exp_bits[i]) bit_q_a.push_back(exp_bits[i]);
      ctr_q_a.push_back(s + 19);
      for (int k = 0; k < n_px; k++) begin
         p.row  = k / 3;
         p.col  = k % 3;
         p.data = int'(pix_mem_a[k]);
         p.cyc  = s + 21 + k;
         px_q_a.push_back(p);
      end
      if (full) begin
         st_q_a.push_back(s + 30);
         dn_q_a.push_back(s + 31);
      end
   endtask

   function automatic int pending_a();
      return bit_q_a.size() + ctr_q_a.size() + px_q_a.size() + st_q_a.size() + dn_q_a.size();
   endfunction

   // ---------------- monitors
   always @(negedge clk) begin
      px_t p;
      int  e;
      if (load_contour_a) begin
         lc_cnt_a++;
         if (bit_q_a.size() == 0) flag("contour_extra_a");
         else begin
            e = bit_q_a.pop_front();
            chk("contour_data_a", contour_data_a, e);
         end
      end
      if (load_center_a) begin
         if (ctr_q_a.size() == 0) flag("center_extra_a");
         else begin
            e = ctr_q_a.pop_front();
            chk("load_center_cycle_a", cyc, e);
         end
      end
      if (enh_ds_ena_a) begin
         if (px_q_a.size() == 0) flag("pixel_extra_a");
         else begin
            p = px_q_a.pop_front();
            chk("pix_cycle_a", cyc, p.cyc);
            chk("pix_row_a", enh_ds_row_a, p.row);
            chk("pix_col_a", enh_ds_col_a, p.col);
            chk("pix_data_a", enh_ds_data_a, p.data);
            chk("contour_rden_a", contour_rden_a, 1);
         end
      end
      if (pix_rden_a && pix_addr_a > 17'd5) flag("pix_addr_range_a");
      if (store_trace_a) begin
         if (st_q_a.size() == 0) flag("store_extra_a");
         else begin
            e = st_q_a.pop_front();
            chk("store_cycle_a", cyc, e);
         end
      end
      if (done_a) begin
         if (dn_q_a.size() == 0) flag("done_extra_a");
         else begin
            e = dn_q_a.pop_front();
            chk("done_cycle_a", cyc, e);
         end
      end
   end

   always @(negedge clk) begin
      int e;
      if (enh_ds_ena_b) ena_cnt_b++;
      if (pix_rden_b && int'(pix_addr_b) > max_addr_b) max_addr_b = int'(pix_addr_b);
      if (store_trace_b) begin
         if (st_q_b.size() == 0) flag("store_extra_b");
         else begin
            e = st_q_b.pop_front();
            chk("store_cycle_b", cyc, e);
         end
      end
      if (done_b) begin
         if (dn_q_b.size() == 0) flag("done_extra_b");
         else begin
            e = dn_q_b.pop_front();
            chk("done_cycle_b", cyc, e);
         end
      end
   end

   // ---------------- stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) tick();
   endtask

   task automatic wait_a(input string name, input int budget);
      int n = 0;
      while (pending_a() != 0 && n < budget) begin
         tick();
         n++;
      end
      if (pending_a() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s timeout pending=%0d required=0", name, pending_a());
         bit_q_a.delete(); ctr_q_a.delete(); px_q_a.delete(); st_q_a.delete(); dn_q_a.delete();
      end
   endtask

   task automatic run_full_a(input string name);
      int s;
      tick();
      s = cyc;
      lc_cnt_a = 0;
      push_pass_a(s, 6, 1'b1);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk({name, "_busy"}, busy_a, 1);
      wait_a(name, 200);
      tick();
      chk({name, "_busy_after"}, busy_a, 0);
      chk({name, "_load_contour_cnt"}, lc_cnt_a, 16);
   endtask

   initial begin
      int s;
      rst_a = 1'b1; start_a = 1'b0;
      rst_b = 1'b1; start_b = 1'b0;
      tick(); tick();
      chk("reset_outs_a", outs_a, 0);
      chk("reset_outs_b", outs_b, 0);

      // start coincident with reset must be dropped
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (5) tick();
      chk("start_in_reset_ignored", outs_a, 0);

      run_full_a("pass1");

      // start pulsed mid-STREAM is ignored; still exactly one done
      tick();
      s = cyc;
      lc_cnt_a = 0;
      push_pass_a(s, 6, 1'b1);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_cyc(s + 22);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_a("pass2", 200);
      repeat (40) tick();
      chk("pass2_busy_after", busy_a, 0);
      chk("pass2_load_contour_cnt", lc_cnt_a, 16);

      // reset mid-STREAM aborts without store_trace or done
      tick();
      s = cyc;
      push_pass_a(s, 2, 1'b0);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_cyc(s + 22);
      rst_a = 1'b1;
      tick();
      chk("abort_reset_outs_a", outs_a, 0);
      rst_a = 1'b0;
      repeat (40) tick();
      chk("abort_pending_a", pending_a(), 0);
      chk("abort_outs_idle_a", outs_a, 0);

      run_full_a("pass_after_abort");

      // default-parameter pass timing and frame boundaries
      tick();
      s = cyc;
      st_q_b.push_back(s + 9*128 + 1 + 76800 + 16 + 1);
      dn_q_b.push_back(s + 9*128 + 1 + 76800 + 16 + 2);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      begin
         int n = 0;
         while (dn_q_b.size() != 0 && n < 80000) begin
            tick();
            n++;
         end
         if (dn_q_b.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL default_pass timeout done_pending=%0d required=0", dn_q_b.size());
         end
      end
      tick();
      chk("default_store_pending", st_q_b.size(), 0);
      chk("default_ena_count", ena_cnt_b, 76800);
      chk("default_pix_addr_max", max_addr_b, 76799);
      chk("default_last_row", enh_ds_row_b, 239);
      chk("default_last_col", enh_ds_col_b, 319);
      chk("default_last_data", enh_ds_data_b, 8'hFF);
      chk("default_busy_after", busy_b, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tracer_chain_driver.md
TRACER_CHAIN_DRIVER -- requirements
Module: tracer_chain_driver

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 240, number of downsampled image rows (max 256).
REQ-002 SHALL have parameter NUM_COLS, default 320, number of downsampled image columns (max 512).
REQ-003 SHALL have parameter CONTOUR_WORDS, default 128, number of 8-bit contour words shifted into the chain.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 16, cycles waited after the last pixel for the chain to settle.
REQ-005 SHALL have port s_axi_aclk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port s_axi_areset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle request to run one trace pass.
REQ-008 SHALL have port busy, output, 1, high from the cycle after accepted start until done.
REQ-009 SHALL have port done, output, 1, one-cycle pulse at pass completion.
REQ-010 SHALL have ports ctr_rden (output, 1), ctr_addr (output, 10) and ctr_rddata (input, 8): contour source memory port with 1-cycle read latency.
REQ-011 SHALL have ports pix_rden (output, 1), pix_addr (output, 17) and pix_rddata (input, 8): pixel source memory port with 1-cycle read latency, raster address row*NUM_COLS+col.
REQ-012 SHALL have ports load_contour (output, 1) and contour_data (output, 1): serial contour load into chain head.
REQ-013 SHALL have port load_center, output, 1, one-cycle pulse latching centers.
REQ-014 SHALL have port contour_rden, output, 1, chain contour-buffer read strobe.
REQ-015 SHALL have ports enh_ds_ena (output, 1), enh_ds_row (output, 8), enh_ds_col (output, 9) and enh_ds_data (output, 8): pixel stream into chain head.
REQ-016 SHALL have port store_trace, output, 1, one-cycle pulse committing accumulated traces.

Function
REQ-017 SHALL implement FSM states IDLE, CTR_FETCH, CTR_SHIFT, CENTER, STREAM, DRAIN, STORE, DONE.
REQ-018 IDLE: start=1 -> CTR_FETCH with word index 0; start in any other state SHALL be ignored.
REQ-019 CTR_FETCH: ctr_rden=1 with ctr_addr=word index for one cycle -> CTR_SHIFT.
REQ-020 CTR_SHIFT: 8 cycles with load_contour=1, contour_data=captured word bit 0..7 (LSB first); then word index increments, -> CTR_FETCH, or after word CONTOUR_WORDS-1 -> CENTER.
REQ-021 load_contour SHALL be 0 in CTR_FETCH cycles; the contour phase SHALL last exactly 9*CONTOUR_WORDS cycles.
REQ-022 CENTER: load_center=1 for exactly one cycle -> STREAM.
REQ-023 STREAM: pix_rden=1 every cycle, col 0..NUM_COLS-1 wrapping to 0 with row+1, for NUM_ROWS*NUM_COLS cycles, no bubbles.
REQ-024 enh_ds_ena, contour_rden, enh_ds_row and enh_ds_col SHALL be registered one cycle after the matching pix_rden, with enh_ds_data=pix_rddata in that cycle.
REQ-025 After the last read, -> DRAIN; the final enh_ds_ena SHALL occur in the first DRAIN cycle.
REQ-026 DRAIN SHALL last DRAIN_CYCLES cycles -> STORE (store_trace=1 for one cycle) -> DONE (done=1 for one cycle) -> IDLE.
REQ-027 Outside their states, every strobe SHALL be 0; enh_ds_row/col/data hold their last values.
REQ-028 Address arithmetic SHALL be incremental, with no multiplier; pix_addr SHALL never exceed NUM_ROWS*NUM_COLS-1.

Reset
REQ-029 s_axi_areset=1 SHALL force IDLE at the next edge from any state, aborting a pass without done or store_trace.
REQ-030 Reset values SHALL be: busy, done, all rden/strobes, contour_data=0; ctr_addr, pix_addr, enh_ds_row, enh_ds_col, enh_ds_data=0.
REQ-031 A start asserted in the same cycle as reset SHALL be ignored.

Structure
REQ-032 The FSM state encoding and the address widths (10, 17, 8, 9) SHALL live in the shared tracer package.
REQ-033 A sub-module tracer_raster_counter (row/col/address generator with last flag) SHALL be instantiated.

Verification
REQ-034 The bench SHALL check: CONTOUR_WORDS=2, words 0xA5, 0x3C -> contour_data sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, load_contour high 16 of 18 cycles.
REQ-035 The bench SHALL check: NUM_ROWS=2, NUM_COLS=3 -> enh_ds_ena for 6 consecutive cycles with (row,col)=(0,0)..(1,2) and data equal to memory[0..5].
REQ-036 The bench SHALL check: a full default pass gives done exactly 9*128+1+76800+16+2 cycles after start, and store_trace is seen once, the cycle before done.
REQ-037 The bench SHALL check: start pulsed during STREAM -> no effect, with a single done.
REQ-038 The bench SHALL check: reset asserted mid-STREAM -> all outputs at reset values the next cycle, no done; a new start then runs a clean pass.
